// File: rtl/ws2812_symbol_decoder_pkg.sv
// ws2812_symbol_decoder_pkg
//   Shared types and constants for the WS2812 symbol decoder:
//   - default 100 MHz timing thresholds (cycles)
//   - decoder FSM state enum
//   - threshold bundle (fields widened to WS_THRESH_W so one struct serves any CNT_W <= 16)
//   - window-compare helper
package ws2812_symbol_decoder_pkg;

  localparam int WS_THRESH_W = 16;

  // Default thresholds at 100 MHz. TRESET_MIN needs CNT_W >= 13.
  localparam logic [WS_THRESH_W-1:0] T0H_MIN_100MHZ    = 16'd30;
  localparam logic [WS_THRESH_W-1:0] T0H_MAX_100MHZ    = 16'd45;
  localparam logic [WS_THRESH_W-1:0] T1H_MIN_100MHZ    = 16'd60;
  localparam logic [WS_THRESH_W-1:0] T1H_MAX_100MHZ    = 16'd90;
  localparam logic [WS_THRESH_W-1:0] TLOW_MAX_100MHZ   = 16'd110;
  localparam logic [WS_THRESH_W-1:0] TRESET_MIN_100MHZ = 16'd5000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    ERR  = 2'd3
  } ws_dec_state_e;

  typedef struct packed {
    logic [WS_THRESH_W-1:0] t0h_min;
    logic [WS_THRESH_W-1:0] t0h_max;
    logic [WS_THRESH_W-1:0] t1h_min;
    logic [WS_THRESH_W-1:0] t1h_max;
    logic [WS_THRESH_W-1:0] tlow_max;
    logic [WS_THRESH_W-1:0] treset_min;
  } ws_dec_thresh_t;

  // Inclusive window test; lo > hi gives an empty window.
  function automatic logic in_window(input logic [WS_THRESH_W-1:0] val,
                                     input logic [WS_THRESH_W-1:0] lo,
                                     input logic [WS_THRESH_W-1:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/ws2812_symbol_decoder_sync_edge.sv
// ws_sync_edge
//   Synchronises the asynchronous data line through SYNC_STAGES flops and keeps
//   a registered copy of the synchronised level for edge detection.
// Ports
//   i_clk, i_reset_n : clock, async active-low reset
//   i_din            : raw asynchronous line
//   o_level          : synchronised line level
//   o_rise / o_fall  : combinational edge flags (level vs. its registered copy)
module ws_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_din,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Synchroniser shift chain plus delayed copy of its output.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], i_din};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign o_level = sync_r[SYNC_STAGES-1];
  assign o_rise  = o_level & ~prev_r;
  assign o_fall  = ~o_level & prev_r;

endmodule

// File: rtl/ws2812_symbol_decoder.sv
// ws2812_symbol_decoder
//   WS2812 serial-line symbol decoder. Measures high/low phase widths with one
//   saturating counter, classifies bits by programmable windows (T1H has
//   priority), polices the low phase, detects the latch gap as end-of-frame and
//   hands bits out through a 1-entry valid/ready buffer.
// Ports
//   i_clk, i_reset_n     : clock, async active-low reset
//   i_enable             : 0 holds FSM in IDLE with counter cleared
//   i_din                : raw WS2812 line
//   i_t0h_min..i_treset_min : live thresholds in cycles
//   o_bit / o_bit_valid / i_bit_ready : decoded bit handshake
//   o_frame_end          : 1-cycle pulse on latch gap
//   o_err_timing         : 1-cycle pulse on window violation
//   o_overflow           : sticky, bit dropped with buffer full; i_clr_err clears
module ws2812_symbol_decoder
  import ws2812_symbol_decoder_pkg::*;
#(
  parameter int CNT_W       = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic             i_din,
  input  logic [CNT_W-1:0] i_t0h_min,
  input  logic [CNT_W-1:0] i_t0h_max,
  input  logic [CNT_W-1:0] i_t1h_min,
  input  logic [CNT_W-1:0] i_t1h_max,
  input  logic [CNT_W-1:0] i_tlow_max,
  input  logic [CNT_W-1:0] i_treset_min,
  output logic             o_bit,
  output logic             o_bit_valid,
  input  logic             i_bit_ready,
  output logic             o_frame_end,
  output logic             o_err_timing,
  output logic             o_overflow,
  input  logic             i_clr_err
);

  logic             level_s, rise_s, fall_s;
  ws_dec_state_e    state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [WS_THRESH_W-1:0] cnt_ext_s;
  ws_dec_thresh_t   thr_s;
  logic             offer_r;
  logic             offer_bit_r;
  logic             ovf_set_s;

  ws_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_din     (i_din),
    .o_level   (level_s),
    .o_rise    (rise_s),
    .o_fall    (fall_s)
  );

  assign thr_s.t0h_min    = WS_THRESH_W'(i_t0h_min);
  assign thr_s.t0h_max    = WS_THRESH_W'(i_t0h_max);
  assign thr_s.t1h_min    = WS_THRESH_W'(i_t1h_min);
  assign thr_s.t1h_max    = WS_THRESH_W'(i_t1h_max);
  assign thr_s.tlow_max   = WS_THRESH_W'(i_tlow_max);
  assign thr_s.treset_min = WS_THRESH_W'(i_treset_min);

  // Counter saturates at all-ones so a stuck line never wraps into a window.
  assign cnt_inc_s = (cnt_r == '1) ? cnt_r : cnt_r + CNT_W'(1);
  assign cnt_ext_s = WS_THRESH_W'(cnt_r);

  // Decoder FSM: phase counting, classification and event pulses.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      offer_r      <= 1'b0;
      offer_bit_r  <= 1'b0;
      o_frame_end  <= 1'b0;
      o_err_timing <= 1'b0;
    end else begin
      offer_r      <= 1'b0;
      o_frame_end  <= 1'b0;
      o_err_timing <= 1'b0;
      cnt_r        <= cnt_inc_s;
      if (!i_enable) begin
        state_r <= IDLE;
        cnt_r   <= '0;
      end else begin
        case (state_r)
          IDLE: begin
            if (rise_s) begin
              state_r <= HIGH;
              cnt_r   <= CNT_W'(1);
            end
          end
          HIGH: begin
            if (fall_s) begin
              if (in_window(cnt_ext_s, thr_s.t1h_min, thr_s.t1h_max)) begin
                offer_r     <= 1'b1;
                offer_bit_r <= 1'b1;
                state_r     <= LOW;
                cnt_r       <= CNT_W'(1);
              end else if (in_window(cnt_ext_s, thr_s.t0h_min, thr_s.t0h_max)) begin
                offer_r     <= 1'b1;
                offer_bit_r <= 1'b0;
                state_r     <= LOW;
                cnt_r       <= CNT_W'(1);
              end else begin
                o_err_timing <= 1'b1;
                state_r      <= ERR;
              end
            end
          end
          LOW: begin
            if (cnt_ext_s == thr_s.treset_min) begin
              o_frame_end <= 1'b1;
              state_r     <= IDLE;
            end else if (rise_s) begin
              if (cnt_ext_s > thr_s.tlow_max) begin
                o_err_timing <= 1'b1;
                state_r      <= ERR;
                cnt_r        <= '0;
              end else begin
                state_r <= HIGH;
                cnt_r   <= CNT_W'(1);
              end
            end
          end
          ERR: begin
            // Every rise restarts the count, so only a genuine latch gap recovers.
            if (rise_s) begin
              cnt_r <= '0;
            end else if (!level_s && (cnt_ext_s == thr_s.treset_min)) begin
              state_r <= IDLE;
            end
          end
          default: begin
            state_r <= IDLE;
            cnt_r   <= '0;
          end
        endcase
      end
    end
  end

  assign ovf_set_s = offer_r & o_bit_valid & ~i_bit_ready;

  // One-entry output buffer with sticky overflow (set beats clear).
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_bit       <= 1'b0;
      o_bit_valid <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      if (offer_r && (!o_bit_valid || i_bit_ready)) begin
        o_bit       <= offer_bit_r;
        o_bit_valid <= 1'b1;
      end else if (!offer_r && o_bit_valid && i_bit_ready) begin
        o_bit_valid <= 1'b0;
      end
      if (ovf_set_s) begin
        o_overflow <= 1'b1;
      end else if (i_clr_err) begin
        o_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ws2812_symbol_decoder.sv
module tb_ws2812_symbol_decoder;

  localparam int CNT_W = 10;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic             din = 1'b0;
  logic             bit_ready = 1'b1;
  logic             clr_err = 1'b0;
  logic [CNT_W-1:0] t0h_min = 10'd16, t0h_max = 10'd24;
  logic [CNT_W-1:0] t1h_min = 10'd32, t1h_max = 10'd44;
  logic [CNT_W-1:0] tlow_max = 10'd60, treset_min = 10'd250;
  logic             o_bit, o_bit_valid, o_frame_end, o_err_timing, o_overflow;

  always #5 clk = ~clk;

  ws2812_symbol_decoder #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_enable(enable), .i_din(din),
    .i_t0h_min(t0h_min), .i_t0h_max(t0h_max), .i_t1h_min(t1h_min), .i_t1h_max(t1h_max),
    .i_tlow_max(tlow_max), .i_treset_min(treset_min),
    .o_bit(o_bit), .o_bit_valid(o_bit_valid), .i_bit_ready(bit_ready),
    .o_frame_end(o_frame_end), .o_err_timing(o_err_timing),
    .o_overflow(o_overflow), .i_clr_err(clr_err)
  );

  int total = 0, bad = 0;
  bit exp_bits[$];
  int exp_frames[$];
  int exp_errs = 0, seen_errs = 0, bits_seen = 0, model_bits = 0;
  int fh[$], fl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: consumes handshakes and event pulses, compares against the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (o_bit_valid && bit_ready) begin
        if (exp_bits.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_bit: got %0d expected none", o_bit);
        end else begin
          check("bit", o_bit, exp_bits.pop_front());
        end
        bits_seen++;
      end
      if (o_frame_end) begin
        if (exp_frames.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_frame_end: got pulse after %0d bits expected none", bits_seen);
        end else begin
          check("frame_end_bitcount", bits_seen, exp_frames.pop_front());
        end
      end
      if (o_err_timing) seen_errs++;
    end
  end

  task automatic push_bit(input bit b);
    exp_bits.push_back(b);
    model_bits++;
  endtask

  // Drive one symbol, aligned to negedges: h cycles high then l cycles low.
  task automatic sym(input int h, input int l);
    din = 1'b1;
    repeat (h) @(negedge clk);
    din = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  // Reference model over the frame in fh/fl (last low is the latch gap), then drive it.
  task automatic play_frame();
    bit err = 1'b0;
    for (int i = 0; i < fh.size(); i++) begin
      if (!err) begin
        if (fh[i] >= 32 && fh[i] <= 44) push_bit(1'b1);
        else if (fh[i] >= 16 && fh[i] <= 24) push_bit(1'b0);
        else begin err = 1'b1; exp_errs++; end
      end
      if (i != fh.size() - 1 && !err && fl[i] > 60) begin
        err = 1'b1;
        exp_errs++;
      end
    end
    if (!err) exp_frames.push_back(model_bits);
    for (int i = 0; i < fh.size(); i++) sym(fh[i], fl[i]);
    fh.delete();
    fl.delete();
  endtask

  task automatic add(input int h, input int l);
    fh.push_back(h);
    fl.push_back(l);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("reset_bit_valid", o_bit_valid, 0);
    check("reset_bit", o_bit, 0);
    check("reset_frame_end", o_frame_end, 0);
    check("reset_err", o_err_timing, 0);
    check("reset_overflow", o_overflow, 0);
    @(negedge clk);
    reset_n = 1'b1;
    enable  = 1'b1;
    repeat (5) @(negedge clk);

    // Basic frame: 0 then 1, latch.
    add(20, 40); add(38, 400); play_frame();
    // Window boundaries.
    add(16, 40); add(24, 40); add(32, 40); add(44, 400); play_frame();
    add(15, 400); play_frame();
    add(25, 400); play_frame();
    add(31, 400); play_frame();
    add(45, 400); play_frame();
    // Dead zone then recovery.
    add(28, 400); play_frame();
    add(20, 400); play_frame();
    // Low phase too long, following symbol dropped; low exactly at the limit is legal.
    add(20, 80); add(20, 400); play_frame();
    add(38, 60); add(20, 1); add(38, 400); play_frame();

    // Randomised frames.
    for (int f = 0; f < 20; f++) begin
      int n = $urandom_range(8, 1);
      for (int s = 0; s < n; s++) begin
        int c = $urandom_range(9, 0);
        int h = (c < 4) ? $urandom_range(24, 16) : (c < 8) ? $urandom_range(44, 32) : $urandom_range(50, 10);
        int l = ($urandom_range(99, 0) < 85) ? $urandom_range(60, 1) : $urandom_range(150, 61);
        add(h, (s == n - 1) ? 400 : l);
      end
      play_frame();
    end

    // Backpressure: first bit held, second dropped, overflow sticky until cleared.
    bit_ready = 1'b0;
    push_bit(1'b1);
    sym(38, 40);
    din = 1'b1;
    repeat (20) @(negedge clk);
    din = 1'b0;
    repeat (6) @(negedge clk);
    check("overflow_set", o_overflow, 1);
    check("hold_valid", o_bit_valid, 1);
    check("hold_bit", o_bit, 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
    check("overflow_cleared", o_overflow, 0);
    check("hold_bit_after_clr", o_bit, 1);
    repeat (32) @(negedge clk);
    // Next bit arrives exactly as the consumer accepts the held one.
    push_bit(1'b0);
    din = 1'b1;
    repeat (20) @(negedge clk);
    din = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("latency_still_old_bit", o_bit, 1);
    bit_ready = 1'b1;
    @(posedge clk);
    #1;
    check("latency_new_bit", o_bit, 0);
    check("latency_new_valid", o_bit_valid, 1);
    check("no_overflow_on_accept", o_overflow, 0);
    exp_frames.push_back(model_bits);
    @(negedge clk);
    repeat (400) @(negedge clk);

    // Enable dropped mid-symbol: silently abandoned.
    din = 1'b1;
    repeat (10) @(negedge clk);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    repeat (5) @(negedge clk);
    din = 1'b0;
    repeat (40) @(negedge clk);
    add(20, 400); play_frame();

    // Async reset mid-HIGH, after leaving o_bit at 1.
    add(38, 400); play_frame();
    din = 1'b1;
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_bit", o_bit, 0);
    check("async_valid", o_bit_valid, 0);
    check("async_frame_end", o_frame_end, 0);
    check("async_err", o_err_timing, 0);
    check("async_overflow", o_overflow, 0);
    din = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    add(38, 400); play_frame();

    repeat (20) @(negedge clk);
    check("bits_drained", exp_bits.size(), 0);
    check("frames_drained", exp_frames.size(), 0);
    check("err_count", seen_errs, exp_errs);
    check("bit_count", bits_seen, model_bits);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
